fifo_rr_arb: RTL and testbench
==============================

FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

Interface
REQ-001 Parameter NUM_IN, default 4: number of requesters; SHALL be 2..16.
REQ-002 Parameter DAT_BITS, default 8: data width per beat.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per grant; SHALL be power of 2, at least 2.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset; asynchronous, active-high.
REQ-006 i_val  input  NUM_IN  per-requester beat valid.
REQ-007 i_dat  input  NUM_IN x DAT_BITS  per-requester beat data.
REQ-008 i_eop  input  NUM_IN  per-requester last-beat-of-packet flag.
REQ-009 o_rdy  output  NUM_IN  per-requester accept; at most one bit high.
REQ-010 o_val  output  1  downstream valid (drives FIFO write valid).
REQ-011 o_dat  output  DAT_BITS  downstream data.
REQ-012 o_eop  output  1  downstream last-beat flag, copied from the source beat.
REQ-013 o_src  output  clog2(NUM_IN)  index of the requester that produced the current o_dat.
REQ-014 i_rdy  input  1  downstream ready (FIFO o_rdy_a).
REQ-015 o_busy  output  1  high while a grant is held.

Function
REQ-016 FSM SHALL have two states: IDLE and GRANT.
REQ-017 IDLE: if any i_val is high, register grant g = first requester with i_val high, searching from (last+1) mod NUM_IN upward with wrap; next state GRANT. Otherwise stay in IDLE.
REQ-018 IDLE SHALL assert no o_rdy bit.
REQ-019 GRANT: o_rdy[g] = ~o_val | i_rdy; all other o_rdy bits SHALL be 0.
REQ-020 A beat is accepted when i_val[g] & o_rdy[g]; on the next edge, o_val=1, o_dat=i_dat[g], o_eop=i_eop[g], o_src=g.
REQ-021 Output register: when o_val & i_rdy and no beat is accepted in the same cycle, o_val SHALL clear next edge; o_dat, o_eop and o_src hold while o_val & ~i_rdy.
REQ-022 Burst counter: clears on grant; increments per accepted beat; width clog2(MAX_BURST)+1.
REQ-023 Release: accepted beat with i_eop[g]=1 OR accepted beat making count == MAX_BURST; next state IDLE and last <= g.
REQ-024 Eop and MAX_BURST on the same beat SHALL count as a single release.
REQ-025 i_val[g] low while in GRANT SHALL hold the grant (no timeout); other requesters wait.
REQ-026 Minimum latency: i_val rising in IDLE at cycle 0 -> o_rdy[g] at cycle 1 -> o_val at cycle 2.
REQ-027 One idle cycle between grants is allowed; sustained throughput within a grant SHALL be 1 beat/cycle while i_rdy=1.
REQ-028 o_busy = (state == GRANT).
REQ-029 A requester SHALL NOT be granted twice in a row while another requester had i_val high at the arbitration cycle.

Reset
REQ-030 On i_rst: state=IDLE, o_val=0, o_dat=0, o_eop=0, o_src=0, count=0, last=NUM_IN-1 (requester 0 wins first), o_rdy=0.
REQ-031 Reset mid-grant SHALL discard the held output beat; no partial packet resumes after reset.

Structure
REQ-032 Shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT).
REQ-033 Sub-module rr_pick (combinational rotate-priority encoder: req vector, last -> grant index, any) SHALL be instantiated once.
REQ-034 A parameter check SHALL call $fatal on an illegal NUM_IN or MAX_BURST.

Verification
REQ-035 Single requester: req1 sends a 3-beat packet (A,B,C, eop on C) with i_rdy=1 -> o_src=1; A,B,C on consecutive cycles starting at cycle 2; o_eop only on C; then IDLE.
REQ-036 All 4 requesters continuously valid with 1-beat packets -> o_src sequence 0,1,2,3,0,1.
REQ-037 Requester 2 streams 40 beats with no eop, MAX_BURST=16, others idle -> grant released after beats 16 and 32; regranted to 2; all 40 beats in order, none lost.
REQ-038 Backpressure: i_rdy low for 5 cycles mid-packet -> o_val, o_dat and o_src held; o_rdy[g]=0; no duplicated or dropped beats.
REQ-039 Reset asserted mid-packet on requester 3 -> all outputs 0 at once; after release, requester 0 is granted first if valid.
REQ-040 Randomized i_val, i_eop and i_rdy, 10k beats -> per-source order preserved, at most one o_rdy bit high, no requester starved beyond NUM_IN grants.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_arb_pkg
// Description : Shared types and constants for the round-robin FIFO arbiter.
//               Holds the arbiter FSM state encoding and the legal ranges
//               of the arbiter parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates, GRANT forwards beats of one requester.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int c_MIN_NUM_IN    = 2;
    localparam int c_MAX_NUM_IN    = 16;
    localparam int c_MIN_MAX_BURST = 2;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_rr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Returns the first
//               requester with its request bit set, searching upward from
//               (i_last + 1) mod NUM_IN and wrapping around.
// Ports       : i_req   - request vector, one bit per requester
//               i_last  - index of the previously served requester
//               o_grant - index of the winning requester (0 when none)
//               o_any   - high when at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         i_req,
    input  logic [$clog2(NUM_IN)-1:0] i_last,
    output logic [$clog2(NUM_IN)-1:0] o_grant,
    output logic                      o_any
);

    localparam int SRC_W = $clog2(NUM_IN);

    logic [SRC_W-1:0] w_idx;

    // Offsets 1..NUM_IN from the last winner; offset NUM_IN is the last
    // winner itself, so it only wins when nobody else is requesting.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            w_idx = SRC_W'((int'(i_last) + i) % NUM_IN);
            if (!o_any && i_req[w_idx]) begin
                o_any   = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arb
// Description : Round-robin packet arbiter feeding a downstream FIFO. Holds a
//               grant for one requester until end-of-packet or MAX_BURST
//               beats, forwarding beats through a single output register.
// Ports       : i_clk, i_rst        - clock, asynchronous active-high reset
//               i_val/i_dat/i_eop   - per-requester beat valid/data/last
//               o_rdy               - per-requester accept (at most one high)
//               o_val/o_dat/o_eop   - downstream beat valid/data/last
//               o_src               - requester index of the current beat
//               i_rdy               - downstream ready
//               o_busy              - high while a grant is held
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int DAT_BITS  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_IN-1:0]            i_val,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
    input  logic [NUM_IN-1:0]            i_eop,
    output logic [NUM_IN-1:0]            o_rdy,
    output logic                         o_val,
    output logic [DAT_BITS-1:0]          o_dat,
    output logic                         o_eop,
    output logic [$clog2(NUM_IN)-1:0]    o_src,
    input  logic                         i_rdy,
    output logic                         o_busy
);

    localparam int SRC_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    if (NUM_IN < c_MIN_NUM_IN || NUM_IN > c_MAX_NUM_IN) begin : g_bad_num_in
        $fatal(1, "fifo_rr_arb: NUM_IN must be in 2..16");
    end
    if (MAX_BURST < c_MIN_MAX_BURST || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_max_burst
        $fatal(1, "fifo_rr_arb: MAX_BURST must be a power of 2, at least 2");
    end

    arb_state_t            state_q, state_d;
    logic [SRC_W-1:0]      grant_q;
    logic [SRC_W-1:0]      last_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  val_q;
    logic [DAT_BITS-1:0]   dat_q;
    logic                  eop_q;
    logic [SRC_W-1:0]      src_q;

    logic [SRC_W-1:0]      w_pick;
    logic                  w_any;
    logic                  w_rdy_g;
    logic                  w_acc;
    logic                  w_rel;
    logic                  w_eop_g;
    logic [DAT_BITS-1:0]   w_dat_g;
    logic [CNT_W-1:0]      w_cnt_inc;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_rr_pick (
        .i_req   (i_val),
        .i_last  (last_q),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    assign w_dat_g   = i_dat[grant_q*DAT_BITS +: DAT_BITS];
    assign w_eop_g   = i_eop[grant_q];
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_acc     = w_rdy_g & i_val[grant_q];
    // End of packet and burst limit on the same beat is one release.
    assign w_rel     = w_acc & (w_eop_g | (w_cnt_inc == CNT_W'(MAX_BURST)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_any) state_d = GRANT;
            GRANT:   if (w_rel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The granted requester may push a beat whenever the
    // output register is empty or being drained this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        o_rdy   = '0;
        o_busy  = 1'b0;
        w_rdy_g = 1'b0;
        if (state_q == GRANT) begin
            o_busy         = 1'b1;
            w_rdy_g        = ~val_q | i_rdy;
            o_rdy[grant_q] = w_rdy_g;
        end
    end

    // ------------------------------------------------------------------
    // Grant, burst counter and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q <= '0;
            last_q  <= SRC_W'(NUM_IN - 1);
            cnt_q   <= '0;
        end else if (state_q == IDLE && w_any) begin
            grant_q <= w_pick;
            cnt_q   <= '0;
        end else if (w_acc) begin
            cnt_q <= w_cnt_inc;
            if (w_rel) begin
                last_q <= grant_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: load on accept, clear when drained without refill
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            val_q <= 1'b0;
            dat_q <= '0;
            eop_q <= 1'b0;
            src_q <= '0;
        end else if (w_acc) begin
            val_q <= 1'b1;
            dat_q <= w_dat_g;
            eop_q <= w_eop_g;
            src_q <= grant_q;
        end else if (i_rdy) begin
            val_q <= 1'b0;
        end
    end

    assign o_val = val_q;
    assign o_dat = dat_q;
    assign o_eop = eop_q;
    assign o_src = src_q;

endmodule : fifo_rr_arb
`default_nettype wire

// File: tb/tb_fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_arb
// Description : Self-checking bench for fifo_rr_arb (NUM_IN=4, DAT_BITS=8,
//               MAX_BURST=16). Per-requester beat queues drive the inputs; a
//               reference arbiter model predicts o_rdy, and accepted beats
//               are pushed to an expected-output queue that is compared
//               against the output register when it is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arb;

    localparam int NUM_IN    = 4;
    localparam int DAT_BITS  = 8;
    localparam int MAX_BURST = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_val = '0;
    logic [31:0] i_dat = '0;
    logic [3:0]  i_eop = '0;
    logic        i_rdy = 1'b0;
    logic [3:0]  o_rdy;
    logic        o_val;
    logic [7:0]  o_dat;
    logic        o_eop;
    logic [1:0]  o_src;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    fifo_rr_arb #(
        .NUM_IN    (NUM_IN),
        .DAT_BITS  (DAT_BITS),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_val  (i_val),
        .i_dat  (i_dat),
        .i_eop  (i_eop),
        .o_rdy  (o_rdy),
        .o_val  (o_val),
        .o_dat  (o_dat),
        .o_eop  (o_eop),
        .o_src  (o_src),
        .i_rdy  (i_rdy),
        .o_busy (o_busy)
    );

    typedef struct packed { logic [7:0] dat; logic eop; } beat_t;
    typedef struct packed { logic [1:0] src; logic [7:0] dat; logic eop; } out_t;

    beat_t       src_q [4][$];
    out_t        exp_out[$];
    logic [9:0]  out_log[$];

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  val_mask = '0;
    bit          rand_mode = 1'b0;
    logic        rdy_val = 1'b1;

    int          m_last = 3;
    int          m_grant = 0;
    int          m_cnt = 0;
    bit          m_busy = 1'b0;

    int          ncyc = 0;
    int          first_out = -1;
    int          rel_cnt = 0;
    bit          prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [3:0] req, input int last);
        int idx;
        for (int i = 1; i <= 4; i++) begin
            idx = (last + i) % 4;
            if (req[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, then
    // advance the model and wait for the next falling edge.
    task automatic tick();
        logic [3:0] exp_rdy;
        beat_t      b;
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() > 0 && val_mask[k] && (!rand_mode || $urandom_range(3) != 0)) begin
                i_val[k]          = 1'b1;
                i_dat[k*8 +: 8]   = src_q[k][0].dat;
                i_eop[k]          = src_q[k][0].eop;
            end else begin
                i_val[k]          = 1'b0;
                i_dat[k*8 +: 8]   = 8'($urandom);
                i_eop[k]          = 1'($urandom);
            end
        end
        i_rdy = rand_mode ? ($urandom_range(3) != 0) : rdy_val;
        #1;
        chk("busy", o_busy, m_busy);
        chk("rdy_onehot", $countones(o_rdy) <= 1, 1);
        exp_rdy = '0;
        if (m_busy && (exp_out.size() == 0 || i_rdy)) exp_rdy[m_grant] = 1'b1;
        chk("o_rdy", o_rdy, exp_rdy);
        chk("o_val", o_val, exp_out.size() != 0);
        if (o_val && first_out < 0) first_out = ncyc;
        if (prev_busy && !o_busy) rel_cnt++;
        prev_busy = o_busy;
        if (exp_out.size() != 0) begin
            chk("o_src", o_src, exp_out[0].src);
            chk("o_dat", o_dat, exp_out[0].dat);
            chk("o_eop", o_eop, exp_out[0].eop);
            if (i_rdy) begin
                out_log.push_back({o_src, o_dat});
                void'(exp_out.pop_front());
            end
        end
        if (m_busy) begin
            if ((exp_rdy & i_val) != 0) begin
                b = src_q[m_grant].pop_front();
                exp_out.push_back({2'(m_grant), b.dat, b.eop});
                m_cnt++;
                if (b.eop || m_cnt == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_last = m_grant;
                end
            end
        end else if (i_val != 0) begin
            m_grant = rr_next(i_val, m_last);
            m_cnt   = 0;
            m_busy  = 1'b1;
        end
        @(negedge i_clk);
        ncyc++;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()
                + exp_out.size()) != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_bound", n < max_cyc, 1);
    endtask

    task automatic wait_out(input int cnt, input int max_cyc);
        int n;
        n = 0;
        while (out_log.size() < cnt && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_out_bound", n < max_cyc, 1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_val = '0;
        i_eop = '0;
        #1;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        exp_out.delete();
        out_log.delete();
        m_busy    = 1'b0;
        m_last    = 3;
        m_cnt     = 0;
        prev_busy = 1'b0;
        first_out = -1;
        rel_cnt   = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_o_val"},  o_val,  0);
        chk({tag, "_o_dat"},  o_dat,  0);
        chk({tag, "_o_eop"},  o_eop,  0);
        chk({tag, "_o_src"},  o_src,  0);
        chk({tag, "_o_rdy"},  o_rdy,  0);
        chk({tag, "_o_busy"}, o_busy, 0);
    endtask

    initial begin
        int         t0;
        logic [9:0] e;

        // Reset values
        #2;
        chk_all_zero("reset");
        do_reset();

        // Single requester, 3-beat packet, minimum latency
        src_q[1].push_back({8'hA1, 1'b0});
        src_q[1].push_back({8'hB2, 1'b0});
        src_q[1].push_back({8'hC3, 1'b1});
        val_mask = 4'b0010;
        rdy_val  = 1'b1;
        t0       = ncyc;
        drain(50);
        tick();
        tick();
        chk("single_latency", first_out - t0, 2);
        chk("single_count", out_log.size(), 3);
        chk("single_beat0", out_log[0], 10'h1A1);
        chk("single_beat1", out_log[1], 10'h1B2);
        chk("single_beat2", out_log[2], 10'h1C3);
        chk("single_idle", o_busy, 0);

        // All requesters valid with 1-beat packets: strict rotation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) src_q[k].push_back({8'(16 * k + j), 1'b1});
        end
        val_mask = 4'b1111;
        drain(100);
        chk("rotate_count", out_log.size(), 8);
        for (int i = 0; i < 6; i++) begin
            e = out_log[i];
            chk("rotate_src", e[9:8], i % 4);
        end

        // Requester 2 streams 40 beats without eop: burst limit releases
        do_reset();
        for (int i = 0; i < 40; i++) src_q[2].push_back({8'(i), 1'b0});
        val_mask = 4'b0100;
        drain(200);
        chk("burst_releases", rel_cnt, 2);
        chk("burst_count", out_log.size(), 40);
        for (int i = 0; i < 40; i++) chk("burst_beat", out_log[i], {2'd2, 8'(i)});
        chk("burst_still_granted", o_busy, 1);

        // Backpressure mid-packet
        do_reset();
        for (int i = 0; i < 6; i++) src_q[0].push_back({8'(8'h50 + i), i == 5});
        val_mask = 4'b0001;
        wait_out(2, 20);
        rdy_val = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_hold_val", o_val, 1);
            chk("bp_hold_dat", o_dat, 8'h52);
            chk("bp_hold_src", o_src, 0);
            chk("bp_rdy_low", o_rdy, 0);
        end
        rdy_val = 1'b1;
        drain(50);
        chk("bp_count", out_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("bp_beat", out_log[i], {2'd0, 8'(8'h50 + i)});

        // Reset mid-packet on requester 3
        do_reset();
        for (int i = 0; i < 8; i++) src_q[3].push_back({8'(8'h70 + i), i == 7});
        val_mask = 4'b1000;
        wait_out(2, 20);
        #2;
        i_rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        do_reset();
        src_q[0].push_back({8'hE0, 1'b1});
        src_q[3].push_back({8'hE3, 1'b1});
        val_mask = 4'b1001;
        drain(30);
        chk("midrst_first", out_log[0], 10'h0E0);
        chk("midrst_second", out_log[1], 10'h3E3);

        // Randomized traffic, 10k beats
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2500; j++) begin
                src_q[k].push_back({8'($urandom), ($urandom_range(3) == 0) || (j == 2499)});
            end
        end
        val_mask  = 4'b1111;
        rand_mode = 1'b1;
        drain(60000);
        rand_mode = 1'b0;
        chk("random_count", out_log.size(), 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_rr_arb
`default_nettype wire
